// File: rtl/bus_pkg.sv
// ---------------------------------------------------------------------------
// bus_pkg
// Shared definitions for the two-master / two-slave bus controller, the Core
// and the Memory model.
//   bus_state_e      : controller FSM encoding (IDLE, ACCESS, WAIT, DONE)
//   GPIO_BIT_DEFAULT : address bit that routes an access to GPIOS
//   OPT_*            : access size / sign codes carried on the option bus
//   WAIT_CNT_W       : width of the slave wait counter
// ---------------------------------------------------------------------------
package bus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        DONE   = 2'd3
    } bus_state_e;

    localparam int GPIO_BIT_DEFAULT = 31;
    localparam int WAIT_CNT_W       = 4;

    // Option codes: bit 2 set means zero-extend (unsigned) on reads.
    localparam logic [2:0] OPT_BYTE   = 3'b000;
    localparam logic [2:0] OPT_HALF   = 3'b001;
    localparam logic [2:0] OPT_WORD   = 3'b010;
    localparam logic [2:0] OPT_BYTE_U = 3'b100;
    localparam logic [2:0] OPT_HALF_U = 3'b101;

endpackage

// File: rtl/rr_arbiter_2.sv
// ---------------------------------------------------------------------------
// rr_arbiter_2
// Purely combinational two-way round-robin grant selection.
//   req_i        : request vector, bit n = master n
//   last_grant_i : master that completed the most recent transaction
//   grant_o      : index of the winning master (valid only when valid_o)
//   valid_o      : at least one master is requesting
// ---------------------------------------------------------------------------
module rr_arbiter_2 (
    input  logic [1:0] req_i,
    input  logic       last_grant_i,
    output logic       grant_o,
    output logic       valid_o
);

    always_comb begin
        grant_o = 1'b0;
        if (req_i == 2'b11) begin
            // Contention: the master that was not served last goes next.
            grant_o = ~last_grant_i;
        end else if (req_i[1]) begin
            grant_o = 1'b1;
        end
    end

    assign valid_o = |req_i;

endmodule

// File: rtl/bus_arbiter.sv
// ---------------------------------------------------------------------------
// bus_arbiter
// Two-master, two-slave bus controller. Grants one transaction at a time
// (round-robin), decodes address[GPIO_BIT] to pick Memory or GPIOS, issues a
// one-cycle slave strobe, waits WAIT_CYCLES, then returns a one-cycle
// response pulse (plus read data) to the granted master.
//   clk, reset                 : clock, asynchronous active-high reset
//   m0_* / m1_*                : master request side (read/write levels,
//                                option, address, write data in; read data
//                                and response pulse out)
//   s_option/s_address/s_write_data : latched transaction fields to slaves
//   memory_read/memory_write, memory_read_data : Memory strobes and data
//   gpio_read/gpio_write, gpio_read_data       : GPIOS strobes and data
//   busy                       : controller is not IDLE
// ---------------------------------------------------------------------------
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int WAIT_CYCLES = 1,
    parameter int GPIO_BIT    = GPIO_BIT_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_read,
    input  logic        m0_write,
    input  logic [2:0]  m0_option,
    input  logic [31:0] m0_address,
    input  logic [31:0] m0_write_data,
    output logic [31:0] m0_read_data,
    output logic        m0_response,
    input  logic        m1_read,
    input  logic        m1_write,
    input  logic [2:0]  m1_option,
    input  logic [31:0] m1_address,
    input  logic [31:0] m1_write_data,
    output logic [31:0] m1_read_data,
    output logic        m1_response,
    output logic [2:0]  s_option,
    output logic [31:0] s_address,
    output logic [31:0] s_write_data,
    output logic        memory_read,
    output logic        memory_write,
    input  logic [31:0] memory_read_data,
    output logic        gpio_read,
    output logic        gpio_write,
    input  logic [31:0] gpio_read_data,
    output logic        busy
);

    localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = WAIT_CNT_W'(WAIT_CYCLES - 1);

    bus_state_e            state_q, state_d;
    logic                  grant_q, grant_d;
    logic                  last_grant_q, last_grant_d;
    logic                  is_write_q, is_write_d;
    logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]            opt_q, opt_d;
    logic [31:0]           addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [31:0]           rdata0_q, rdata0_d;
    logic [31:0]           rdata1_q, rdata1_d;

    logic                  arb_grant;
    logic                  arb_valid;
    logic                  sel_gpio;
    logic [31:0]           slave_rdata;

    rr_arbiter_2 u_rr (
        .req_i        ({m1_read | m1_write, m0_read | m0_write}),
        .last_grant_i (last_grant_q),
        .grant_o      (arb_grant),
        .valid_o      (arb_valid)
    );

    assign sel_gpio    = addr_q[GPIO_BIT];
    assign slave_rdata = sel_gpio ? gpio_read_data : memory_read_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;   // master 0 wins the first contended grant
            is_write_q   <= 1'b0;
            cnt_q        <= '0;
            opt_q        <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            is_write_q   <= is_write_d;
            cnt_q        <= cnt_d;
            opt_q        <= opt_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        is_write_d   = is_write_q;
        cnt_d        = cnt_q;
        opt_d        = opt_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;

        unique case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    grant_d = arb_grant;
                    // A simultaneous read+write is treated as a write.
                    if (arb_grant) begin
                        is_write_d = m1_write;
                        opt_d      = m1_option;
                        addr_d     = m1_address;
                        wdata_d    = m1_write_data;
                    end else begin
                        is_write_d = m0_write;
                        opt_d      = m0_option;
                        addr_d     = m0_address;
                        wdata_d    = m0_write_data;
                    end
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                cnt_d   = WAIT_LOAD;
                state_d = WAIT;
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    // Capture on the WAIT->DONE edge so the data is already
                    // presented to the master alongside its response pulse.
                    if (!is_write_q) begin
                        if (grant_q) begin
                            rdata1_d = slave_rdata;
                        end else begin
                            rdata0_d = slave_rdata;
                        end
                    end
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - WAIT_CNT_W'(1);
                end
            end
            DONE: begin
                last_grant_d = grant_q;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Strobes and responses decode straight from state so reset removes
    // them without waiting for a clock edge.
    assign memory_read  = (state_q == ACCESS) && !is_write_q && !sel_gpio;
    assign memory_write = (state_q == ACCESS) &&  is_write_q && !sel_gpio;
    assign gpio_read    = (state_q == ACCESS) && !is_write_q &&  sel_gpio;
    assign gpio_write   = (state_q == ACCESS) &&  is_write_q &&  sel_gpio;

    assign m0_response  = (state_q == DONE) && !grant_q;
    assign m1_response  = (state_q == DONE) &&  grant_q;
    assign m0_read_data = rdata0_q;
    assign m1_read_data = rdata1_q;

    assign s_option     = opt_q;
    assign s_address    = addr_q;
    assign s_write_data = wdata_q;
    assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_bus_arbiter.sv
module tb_bus_arbiter;
    import bus_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic [2:0]  m0_option, m1_option;
    logic [31:0] m0_address, m0_write_data, m1_address, m1_write_data;
    logic [31:0] memory_read_data, gpio_read_data;

    // Outputs of the WAIT_CYCLES=1 instance (_1) and WAIT_CYCLES=4 instance (_4)
    logic [31:0] m0_read_data_1, m1_read_data_1, s_address_1, s_write_data_1;
    logic [2:0]  s_option_1;
    logic        m0_response_1, m1_response_1, memory_read_1, memory_write_1;
    logic        gpio_read_1, gpio_write_1, busy_1;
    logic [31:0] m0_read_data_4, m1_read_data_4, s_address_4, s_write_data_4;
    logic [2:0]  s_option_4;
    logic        m0_response_4, m1_response_4, memory_read_4, memory_write_4;
    logic        gpio_read_4, gpio_write_4, busy_4;

    int nvec = 0;
    int nmiss = 0;

    always #5 clk = ~clk;

    bus_arbiter #(.WAIT_CYCLES(1)) u_dut1 (
        .clk(clk), .reset(reset),
        .m0_read(m0_read), .m0_write(m0_write), .m0_option(m0_option),
        .m0_address(m0_address), .m0_write_data(m0_write_data),
        .m0_read_data(m0_read_data_1), .m0_response(m0_response_1),
        .m1_read(m1_read), .m1_write(m1_write), .m1_option(m1_option),
        .m1_address(m1_address), .m1_write_data(m1_write_data),
        .m1_read_data(m1_read_data_1), .m1_response(m1_response_1),
        .s_option(s_option_1), .s_address(s_address_1), .s_write_data(s_write_data_1),
        .memory_read(memory_read_1), .memory_write(memory_write_1),
        .memory_read_data(memory_read_data),
        .gpio_read(gpio_read_1), .gpio_write(gpio_write_1),
        .gpio_read_data(gpio_read_data), .busy(busy_1)
    );

    bus_arbiter #(.WAIT_CYCLES(4)) u_dut4 (
        .clk(clk), .reset(reset),
        .m0_read(m0_read), .m0_write(m0_write), .m0_option(m0_option),
        .m0_address(m0_address), .m0_write_data(m0_write_data),
        .m0_read_data(m0_read_data_4), .m0_response(m0_response_4),
        .m1_read(m1_read), .m1_write(m1_write), .m1_option(m1_option),
        .m1_address(m1_address), .m1_write_data(m1_write_data),
        .m1_read_data(m1_read_data_4), .m1_response(m1_response_4),
        .s_option(s_option_4), .s_address(s_address_4), .s_write_data(s_write_data_4),
        .memory_read(memory_read_4), .memory_write(memory_write_4),
        .memory_read_data(memory_read_data),
        .gpio_read(gpio_read_4), .gpio_write(gpio_write_4),
        .gpio_read_data(gpio_read_data), .busy(busy_4)
    );

    // Transaction-level reference: a transaction is "active" with an age
    // counted in cycles since its grant (1 = strobe cycle, W+2 = response).
    typedef struct {
        bit          active;
        int          age;
        bit          g;
        bit          lastg;
        bit          wr;
        logic [2:0]  opt;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rd0;
        logic [31:0] rd1;
    } mdl_t;

    mdl_t md1, md4;

    function automatic mdl_t mdl_reset();
        mdl_t m;
        m.active = 0; m.age = 0; m.g = 0; m.lastg = 1; m.wr = 0;
        m.opt = '0; m.addr = '0; m.wdata = '0; m.rd0 = '0; m.rd1 = '0;
        return m;
    endfunction

    // Advance the model across one rising edge using the current inputs.
    function automatic mdl_t mdl_step(mdl_t m, int w);
        bit r0, r1;
        if (reset) return mdl_reset();
        r0 = m0_read | m0_write;
        r1 = m1_read | m1_write;
        if (!m.active) begin
            if (r0 || r1) begin
                if (r0 && r1) m.g = !m.lastg;
                else          m.g = r1;
                m.wr    = m.g ? m1_write      : m0_write;
                m.opt   = m.g ? m1_option     : m0_option;
                m.addr  = m.g ? m1_address    : m0_address;
                m.wdata = m.g ? m1_write_data : m0_write_data;
                m.active = 1;
                m.age    = 1;
            end
        end else begin
            if (m.age == w + 1 && !m.wr) begin
                if (m.g) m.rd1 = m.addr[31] ? gpio_read_data : memory_read_data;
                else     m.rd0 = m.addr[31] ? gpio_read_data : memory_read_data;
            end
            if (m.age == w + 2) begin
                m.active = 0;
                m.lastg  = m.g;
            end else begin
                m.age++;
            end
        end
        return m;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nmiss++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_dut(string t, mdl_t m, int w,
                             logic [31:0] rd0, logic [31:0] rd1, logic rsp0, logic rsp1,
                             logic [2:0] sopt, logic [31:0] saddr, logic [31:0] swd,
                             logic mr, logic mw, logic gr, logic gw, logic bsy);
        bit strobe, gp, resp;
        strobe = m.active && m.age == 1;
        resp   = m.active && m.age == w + 2;
        gp     = m.addr[31];
        chk({t, ".busy"},  {31'd0, bsy},  {31'd0, m.active});
        chk({t, ".mem_rd"}, {31'd0, mr},  {31'd0, strobe && !m.wr && !gp});
        chk({t, ".mem_wr"}, {31'd0, mw},  {31'd0, strobe &&  m.wr && !gp});
        chk({t, ".gpio_rd"}, {31'd0, gr}, {31'd0, strobe && !m.wr &&  gp});
        chk({t, ".gpio_wr"}, {31'd0, gw}, {31'd0, strobe &&  m.wr &&  gp});
        chk({t, ".m0_resp"}, {31'd0, rsp0}, {31'd0, resp && !m.g});
        chk({t, ".m1_resp"}, {31'd0, rsp1}, {31'd0, resp &&  m.g});
        chk({t, ".m0_rdata"}, rd0, m.rd0);
        chk({t, ".m1_rdata"}, rd1, m.rd1);
        chk({t, ".s_option"}, {29'd0, sopt}, {29'd0, m.opt});
        chk({t, ".s_address"}, saddr, m.addr);
        chk({t, ".s_wdata"}, swd, m.wdata);
    endtask

    task automatic check_all();
        check_dut("w1", md1, 1, m0_read_data_1, m1_read_data_1, m0_response_1, m1_response_1,
                  s_option_1, s_address_1, s_write_data_1, memory_read_1, memory_write_1,
                  gpio_read_1, gpio_write_1, busy_1);
        check_dut("w4", md4, 4, m0_read_data_4, m1_read_data_4, m0_response_4, m1_response_4,
                  s_option_4, s_address_4, s_write_data_4, memory_read_4, memory_write_4,
                  gpio_read_4, gpio_write_4, busy_4);
    endtask

    task automatic tick();
        @(posedge clk);
        md1 = mdl_step(md1, 1);
        md4 = mdl_step(md4, 4);
        #1;
        check_all();
    endtask

    task automatic drain();
        m0_read = 0; m0_write = 0; m1_read = 0; m1_write = 0;
        for (int i = 0; i < 8; i++) tick();
    endtask

    task automatic async_reset();
        reset = 1'b1;
        md1 = mdl_reset();
        md4 = mdl_reset();
        #1;
        check_all();
    endtask

    initial begin
        int c0, c1, cmr, cmw, crsp;
        reset = 1'b1;
        m0_read = 0; m0_write = 0; m1_read = 0; m1_write = 0;
        m0_option = '0; m1_option = '0;
        m0_address = '0; m1_address = '0; m0_write_data = '0; m1_write_data = '0;
        memory_read_data = '0; gpio_read_data = '0;
        md1 = mdl_reset();
        md4 = mdl_reset();
        tick();
        tick();
        reset = 1'b0;
        tick();

        // Master 0 reads memory
        m0_read = 1; m0_option = OPT_WORD; m0_address = 32'h0000_0010;
        memory_read_data = 32'hDEAD_BEEF; gpio_read_data = 32'h1234_5678;
        for (int i = 0; i < 7; i++) tick();
        chk("s1.m0_rdata_w1", m0_read_data_1, 32'hDEAD_BEEF);
        chk("s1.m0_rdata_w4", m0_read_data_4, 32'hDEAD_BEEF);
        drain();

        // Master 1 writes GPIO
        m1_write = 1; m1_option = OPT_WORD; m1_address = 32'h8000_0004;
        m1_write_data = 32'h0000_00A5;
        for (int i = 0; i < 6; i++) tick();
        drain();
        chk("s2.s_address_w4", s_address_4, 32'h8000_0004);
        chk("s2.s_wdata_w4", s_write_data_4, 32'h0000_00A5);
        chk("s2.m1_rdata_w4", m1_read_data_4, 32'h0);

        // Both masters read continuously
        m0_read = 1; m1_read = 1; m0_address = 32'h0000_0100; m1_address = 32'h8000_0200;
        c0 = 0; c1 = 0;
        for (int i = 0; i < 24; i++) begin
            memory_read_data = $urandom();
            gpio_read_data   = $urandom();
            tick();
            c0 += int'(m0_response_1);
            c1 += int'(m1_response_1);
        end
        chk("s3.m0_resp_count", c0, 3);
        chk("s3.m1_resp_count", c1, 3);
        drain();

        // Read and write together on master 0
        m0_read = 1; m0_write = 1; m0_address = 32'h0000_0020; m0_write_data = 32'hCAFE_0001;
        cmr = 0; cmw = 0; crsp = 0;
        for (int i = 0; i < 12; i++) begin
            if (i == 6) begin m0_read = 0; m0_write = 0; end
            tick();
            cmr  += int'(memory_read_4);
            cmw  += int'(memory_write_4);
            crsp += int'(m0_response_4);
        end
        chk("s4.mem_rd_count", cmr, 0);
        chk("s4.mem_wr_count", cmw, 1);
        chk("s4.resp_count", crsp, 1);
        drain();

        // Reset during WAIT, then master 0 wins first grant
        m0_read = 1; m0_address = 32'h0000_0100; m1_address = 32'h0000_0200;
        tick(); tick(); tick();
        #2;
        async_reset();
        chk("s5.busy_async_w4", busy_4, 1'b0);
        m1_read = 1;
        tick();
        reset = 1'b0;
        tick();
        chk("s5.first_grant_w4", s_address_4, 32'h0000_0100);
        drain();

        // Request dropped during WAIT still completes
        m0_read = 1; m0_address = 32'h0000_0044; memory_read_data = 32'h1357_2468;
        tick(); tick();
        drain();
        chk("s6.m0_rdata_w4", m0_read_data_4, 32'h1357_2468);
        chk("s6.m0_rdata_w1", m0_read_data_1, 32'h1357_2468);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            m0_read  = ($urandom_range(0, 3) == 0);
            m0_write = ($urandom_range(0, 4) == 0);
            m1_read  = ($urandom_range(0, 3) == 0);
            m1_write = ($urandom_range(0, 4) == 0);
            m0_option = 3'($urandom_range(0, 7));
            m1_option = 3'($urandom_range(0, 7));
            m0_address = $urandom(); m1_address = $urandom();
            m0_write_data = $urandom(); m1_write_data = $urandom();
            memory_read_data = $urandom(); gpio_read_data = $urandom();
            if ($urandom_range(0, 99) == 0) begin
                #3;
                async_reset();
                tick();
                reset = 1'b0;
            end
            tick();
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmiss);
        $finish;
    end

endmodule
